// File: rtl/thunderbird_lamp_monitor.sv
// Decodes the thunderbird lamp pattern stream back into LEFT/RIGHT/HAZARD sequences,
// pulsing done on each completed sequence and err on any illegal pattern or transition.
module thunderbird_lamp_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [5:0]       lamps,
    input  logic             clr_cnt,
    output logic [1:0]       mode,
    output logic [1:0]       phase,
    output logic             done,
    output logic             err,
    output logic [5:0]       err_pattern,
    output logic [CNT_W-1:0] seq_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [5:0] P_OFF = 6'b000000;
    localparam logic [5:0] P_L1  = 6'b100000;
    localparam logic [5:0] P_L2  = 6'b110000;
    localparam logic [5:0] P_L3  = 6'b111000;
    localparam logic [5:0] P_R1  = 6'b000100;
    localparam logic [5:0] P_R2  = 6'b000110;
    localparam logic [5:0] P_R3  = 6'b000111;
    localparam logic [5:0] P_HAZ = 6'b111111;

    typedef enum logic [2:0] {
        S_OFF,
        S_L1,
        S_L2,
        S_L3,
        S_R1,
        S_R2,
        S_R3,
        S_H
    } state_t;

    state_t           state_q, state_d;
    state_t           offNext, expNext;
    logic             offLegal;
    logic [5:0]       expPat;
    logic             endsSeq;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       phase_q, phase_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [5:0]       errPat_q, errPat_d;
    logic [CNT_W-1:0] seqCnt_q, seqCnt_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    // Where the OFF row sends a pattern; also the resync target after an error.
    always_comb begin
        offNext  = S_OFF;
        offLegal = 1'b0;
        case (lamps)
            P_L1:    begin offNext = S_L1;  offLegal = 1'b1; end
            P_R1:    begin offNext = S_R1;  offLegal = 1'b1; end
            P_HAZ:   begin offNext = S_H;   offLegal = 1'b1; end
            P_OFF:   begin offNext = S_OFF; offLegal = 1'b1; end
            default: begin offNext = S_OFF; offLegal = 1'b0; end
        endcase
    end

    always_comb begin
        expPat  = P_OFF;
        expNext = S_OFF;
        endsSeq = 1'b0;
        case (state_q)
            S_L1:    begin expPat = P_L2;  expNext = S_L2;  end
            S_L2:    begin expPat = P_L3;  expNext = S_L3;  end
            S_R1:    begin expPat = P_R2;  expNext = S_R2;  end
            S_R2:    begin expPat = P_R3;  expNext = S_R3;  end
            S_L3, S_R3, S_H: begin
                expPat  = P_OFF;
                expNext = S_OFF;
                endsSeq = 1'b1;
            end
            default: begin expPat = P_OFF; expNext = S_OFF; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (sample_en) begin
            if (state_q == S_OFF) begin
                state_d = offNext;
                err_d   = !offLegal;
            end else if (lamps == expPat) begin
                state_d = expNext;
                done_d  = endsSeq;
            end else begin
                state_d = offNext;
                err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        mode_d  = 2'd0;
        phase_d = 2'd0;
        case (state_d)
            S_L1:    begin mode_d = 2'd1; phase_d = 2'd1; end
            S_L2:    begin mode_d = 2'd1; phase_d = 2'd2; end
            S_L3:    begin mode_d = 2'd1; phase_d = 2'd3; end
            S_R1:    begin mode_d = 2'd2; phase_d = 2'd1; end
            S_R2:    begin mode_d = 2'd2; phase_d = 2'd2; end
            S_R3:    begin mode_d = 2'd2; phase_d = 2'd3; end
            S_H:     begin mode_d = 2'd3; phase_d = 2'd1; end
            default: begin mode_d = 2'd0; phase_d = 2'd0; end
        endcase
    end

    // Clear wins over a coincident increment; both counters stick at all-ones.
    always_comb begin
        seqCnt_d = seqCnt_q;
        errCnt_d = errCnt_q;
        errPat_d = errPat_q;
        if (clr_cnt) begin
            seqCnt_d = '0;
            errCnt_d = '0;
            errPat_d = '0;
        end else begin
            if (done_d && (seqCnt_q != '1)) begin
                seqCnt_d = seqCnt_q + 1'b1;
            end
            if (err_d) begin
                errPat_d = lamps;
                if (errCnt_q != '1) begin
                    errCnt_d = errCnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_OFF;
            mode_q   <= 2'd0;
            phase_q  <= 2'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            errPat_q <= '0;
            seqCnt_q <= '0;
            errCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
            err_q    <= err_d;
            errPat_q <= errPat_d;
            seqCnt_q <= seqCnt_d;
            errCnt_q <= errCnt_d;
        end
    end

    assign mode        = mode_q;
    assign phase       = phase_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_pattern = errPat_q;
    assign seq_cnt     = seqCnt_q;
    assign err_cnt     = errCnt_q;

endmodule
